// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the control unit, a word-wide data memory and the data register.
// Optional wait-state abort is enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        dr_in,
  output logic        dr_out,
  output logic [31:0] dr_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned SW  = 2;

  localparam logic [SW-1:0] SZ_B   = 2'b00;
  localparam logic [SW-1:0] SZ_H   = 2'b01;
  localparam logic [SW-1:0] SZ_W   = 2'b10;
  localparam logic [SW-1:0] SZ_RSV = 2'b11;

  if (TIMEOUT_CYC == 0) begin : g_cfg_check
    $error("TIMEOUT_CYC must be nonzero");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [SW-1:0]   size_q, size_d;
  logic            sext_q, sext_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [BEW-1:0]  mem_be_q, mem_be_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            dr_in_q, dr_in_d;
  logic            dr_out_q, dr_out_d;
  logic [DW-1:0]   dr_wdata_q, dr_wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            legal_c;
  logic            mem_act_c;
  logic [BEW-1:0]  be_c;
  logic [DW-1:0]   rep_c;
  logic [DW-1:0]   load_c;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
`endif

  assign legal_c = (size != SZ_RSV) &&
                   !((size == SZ_H) && addr[0]) &&
                   !((size == SZ_W) && (addr[1:0] != 2'b00));

  // Lane enables and store-data replication for the access being presented next cycle.
  always_comb begin
    be_c  = '0;
    rep_c = '0;
    unique case (size_d)
      SZ_B: begin
        be_c  = BEW'(1) << addr_d[1:0];
        rep_c = {4{wdata_d[7:0]}};
      end
      SZ_H: begin
        be_c  = addr_d[1] ? 4'b1100 : 4'b0011;
        rep_c = {2{wdata_d[15:0]}};
      end
      SZ_W: begin
        be_c  = 4'b1111;
        rep_c = wdata_d;
      end
      default: begin
        be_c  = '0;
        rep_c = '0;
      end
    endcase
  end

  // Lane extraction and extension of the returned memory word.
  always_comb begin
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    unique case (addr_q[1:0])
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_c = mem_rdata;
    unique case (size_q)
      SZ_B:    load_c = sext_q ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
      SZ_H:    load_c = sext_q ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    dr_out_d   = dr_out_q;
    dr_wdata_d = dr_wdata_q;
`ifdef MEM_TIMEOUT_EN
    wcnt_d     = wcnt_q;
`endif

    unique case (state_q)
      // HOLD accepts a new request exactly like IDLE; dr_out drops on acceptance.
      IDLE, HOLD: begin
        if (req) begin
          if (legal_c) begin
            state_d  = ISSUE;
            we_d     = we;
            size_d   = size;
            sext_d   = sext;
            addr_d   = addr;
            wdata_d  = wdata;
            dr_out_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE, WAIT: begin
        if (mem_ready) begin
          state_d = we_q ? IDLE : CAPTURE;
          done_d  = we_q;
        end else begin
          state_d = WAIT;
`ifdef MEM_TIMEOUT_EN
          if (state_q == ISSUE) begin
            wcnt_d = '0;
          end else if (wcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
`endif
        end
      end
      CAPTURE: begin
        state_d  = HOLD;
        done_d   = 1'b1;
        dr_out_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    mem_act_c   = (state_d == ISSUE) || (state_d == WAIT);
    mem_en_d    = mem_act_c;
    mem_we_d    = mem_act_c & we_d;
    mem_addr_d  = mem_act_c ? {addr_d[31:2], 2'b00} : '0;
    mem_be_d    = mem_act_c ? be_c : '0;
    mem_wdata_d = mem_act_c ? rep_c : '0;
    dr_in_d     = (state_d == CAPTURE);
    busy_d      = mem_act_c || (state_d == CAPTURE);
    if (dr_in_d) begin
      dr_wdata_d = load_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      dr_in_q     <= 1'b0;
      dr_out_q    <= 1'b0;
      dr_wdata_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      dr_in_q     <= dr_in_d;
      dr_out_q    <= dr_out_d;
      dr_wdata_q  <= dr_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef MEM_TIMEOUT_EN
      wcnt_q      <= wcnt_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign dr_in     = dr_in_q;
  assign dr_out    = dr_out_q;
  assign dr_wdata  = dr_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a transaction-timeline model sets the expected outputs for every cycle,
// a negedge process compares them, and literal checks pin the model on the canonical cases.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sext, mem_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_en, mem_we, dr_in, dr_out, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, dr_wdata;
  logic [3:0]  mem_be;

  mem_access_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .dr_in(dr_in), .dr_out(dr_out), .dr_wdata(dr_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, plus the persistent data-register model.
  logic        e_mem_en, e_mem_we, e_dr_in, e_dr_out, e_busy, e_done, e_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_dr_wdata;
  logic [3:0]  e_mem_be;
  logic        m_dr_out;
  logic [31:0] m_dr_wdata;

  // Observation counters and snapshots used by the literal checks.
  int n_done, n_drin, n_en, n_busy, n_err, done_cyc;
  logic [3:0]  snap_be;
  logic [31:0] snap_wd, snap_dr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("mem_en", 32'(mem_en), 32'(e_mem_en));
    chk("mem_we", 32'(mem_we), 32'(e_mem_we));
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_be", 32'(mem_be), 32'(e_mem_be));
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("dr_in", 32'(dr_in), 32'(e_dr_in));
    chk("dr_out", 32'(dr_out), 32'(e_dr_out));
    chk("dr_wdata", dr_wdata, e_dr_wdata);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    if (done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (dr_in === 1'b1) begin n_drin++; snap_dr = dr_wdata; end
    if (mem_en === 1'b1) begin n_en++; snap_be = mem_be; snap_wd = mem_wdata; end
    if (busy === 1'b1) n_busy++;
    if (err === 1'b1) n_err++;
  end

  function automatic logic legal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b00) || (sz == 2'b01 && !a[0]) || (sz == 2'b10 && a[1:0] == 2'b00);
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rep_of(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ext_of(input logic [1:0] sz, input logic sx,
                                         input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[int'(off) * 8 +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   return sx ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sx ? {{16{h[15]}}, h} : {16'h0, h};
      default: return rd;
    endcase
  endfunction

  task automatic set_idle();
    e_mem_en = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_be = 0; e_mem_wdata = 0;
    e_dr_in = 0; e_busy = 0; e_done = 0; e_err = 0;
    e_dr_out = m_dr_out; e_dr_wdata = m_dr_wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic set_mem(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    e_busy = 1; e_mem_en = 1; e_mem_we = w; e_mem_addr = {a[31:2], 2'b00};
    e_mem_be = be_of(sz, a[1:0]); e_mem_wdata = rep_of(sz, wd);
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      mem_ready = noise;
      mem_rdata = $urandom;
      step();
    end
    mem_ready = 0;
  endtask

  // One access as seen by the control unit; abort_at>0 asserts rst in that WAIT cycle.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int nwait, input bit hold, input int abort_at, output int t0);
    int last;
    bit timed_out;
    req = 1; we = w; size = sz; sext = sx; addr = a; wdata = wd; mem_ready = 0;
    t0 = cyc;
    step();
    if (!legal(sz, a)) begin
      req = 0;
      e_err = 1;
      return;
    end
    if (!hold) req = 0;
    m_dr_out = 0;
    set_idle();
    set_mem(w, sz, a, wd);
    mem_ready = (nwait == 0);
    mem_rdata = (nwait == 0) ? rd : ~rd;
    last = nwait;
    timed_out = 0;
`ifdef MEM_TIMEOUT_EN
    if (nwait > 16) begin last = 16; timed_out = 1; end
`endif
    for (int k = 1; k <= last; k++) begin
      step();
      set_mem(w, sz, a, wd);
      mem_ready = (k == nwait);
      mem_rdata = (k == nwait) ? rd : $urandom;
      if (abort_at == k) begin
        mem_ready = 0;
        #2 rst = 1;
        m_dr_out = 0; m_dr_wdata = 0;
        set_idle();
        #1;
        chk("rst_async_mem_en", 32'(mem_en), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_mem_be", 32'(mem_be), 32'd0);
        step();
        rst = 0; req = 0;
        return;
      end
    end
    step();
    mem_ready = 0;
    mem_rdata = $urandom;
    if (timed_out) begin
      req = 0;
      e_err = 1;
      return;
    end
    if (w) begin
      req = 0;
      e_done = 1;
      return;
    end
    e_busy = 1; e_dr_in = 1;
    m_dr_wdata = ext_of(sz, sx, a[1:0], rd);
    e_dr_wdata = m_dr_wdata;
    step();
    req = 0;
    m_dr_out = 1;
    e_dr_out = 1; e_done = 1;
  endtask

  task automatic clr_obs();
    n_done = 0; n_drin = 0; n_en = 0; n_busy = 0; n_err = 0;
  endtask

  initial begin
    int t0;
    rst = 1; req = 0; we = 0; size = 0; sext = 0; addr = 0; wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    m_dr_out = 0; m_dr_wdata = 0;
    set_idle();
    clr_obs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    idle(3, 1'b1);

    // Load byte, sign-extended, two wait states.
    clr_obs();
    access(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_FF12, 2, 1'b0, 0, t0);
    idle(2, 1'b0);
    chk("ldb_be", 32'(snap_be), 32'h8);
    chk("ldb_dr_wdata", snap_dr, 32'hFFFF_FF80);
    chk("ldb_dr_in_cycles", n_drin, 1);
    chk("ldb_done_pulses", n_done, 1);

    // Store halfword, zero wait states.
    clr_obs();
    access(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 1'b0, 0, t0);
    idle(1, 1'b0);
    chk("sth_be", 32'(snap_be), 32'hC);
    chk("sth_wdata", snap_wd, 32'hABCD_ABCD);
    chk("sth_latency", done_cyc - t0 + 1, 3);

    // Misaligned word load.
    clr_obs();
    access(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 1'b0, 0, t0);
    idle(2, 1'b0);
    chk("misal_err_pulses", n_err, 1);
    chk("misal_mem_en_cycles", n_en, 0);
    chk("misal_busy_cycles", n_busy, 0);

    // Further load/store patterns and illegal encodings.
    access(1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0, 32'h8765_4321, 1, 1'b0, 0, t0);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0, 32'h1234_F00D, 0, 1'b0, 0, t0);
    idle(1, 1'b0);
    chk("ldh_sext", snap_dr, 32'hFFFF_F00D);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'hAABB_CCDD, 0, 1'b0, 0, t0);
    idle(1, 1'b1);
    chk("ldb_zext", snap_dr, 32'h0000_00CC);
    access(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_56A5, 32'h0, 0, 1'b0, 0, t0);
    chk("stb_wdata", snap_wd, 32'hA5A5_A5A5);
    access(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 0, t0);
    clr_obs();
    access(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h1357_9BDF, 0, 1'b0, 0, t0);
    idle(1, 1'b0);
    chk("ldw_latency", done_cyc - t0 + 1, 4);
    chk("ldw_data", snap_dr, 32'h1357_9BDF);
    access(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 1'b0, 0, t0);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0007, 32'h0, 32'h0, 0, 1'b0, 0, t0);
    idle(1, 1'b0);

    // Reset during the WAIT of a load, then a clean load from address 0.
    clr_obs();
    access(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 4, 1'b0, 2, t0);
    idle(2, 1'b0);
    chk("abort_dr_in", n_drin, 0);
    chk("abort_done", n_done, 0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0055, 0, 1'b0, 0, t0);
    idle(1, 1'b0);
    chk("post_rst_load", snap_dr, 32'h0000_0055);

    // Request held through busy, then an immediate second load.
    clr_obs();
    access(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0, 32'h0077_0000, 2, 1'b1, 0, t0);
    access(1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'h0, 32'h4444_3333, 1, 1'b1, 0, t0);
    idle(2, 1'b0);
    chk("held_req_done_pulses", n_done, 2);

    // Long wait: completes by default, aborts when the timeout is built in.
    access(1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, 32'h0BAD_CAFE, 20, 1'b0, 0, t0);
    idle(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
